// File: rtl/reaction_state_sequencer.sv
// Top-level state sequencer for the reaction timer: owns the one-hot enable
// vector and moves between IDLE/WAIT/GO/RESULT/FALSE on armed request codes.
module reaction_state_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] st_idle,
  input  logic [3:0] st_wait,
  input  logic [3:0] st_go,
  input  logic [3:0] st_result,
  input  logic [3:0] st_false,
  output logic [4:0] en,
  output logic [2:0] state,
  output logic       changed,
  output logic       err_illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_GO     = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_FALSE  = 3'd4;

  localparam logic [3:0] C_NONE   = 4'd0;
  localparam logic [3:0] C_WAIT   = 4'd1;
  localparam logic [3:0] C_GO     = 4'd2;
  localparam logic [3:0] C_RESULT = 4'd3;
  localparam logic [3:0] C_FALSE  = 4'd4;
  localparam logic [3:0] C_IDLE   = 4'd15;

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_tmo;
  logic             r_zero_seen;
  logic             r_changed;
  logic             r_err;

  logic [3:0]       w_req;
  logic             w_legal;
  logic [2:0]       w_target;
  logic             w_bad_state;
  logic             w_terminal;
  logic             w_armed;
  logic             w_accept;
  logic             w_illegal;
  logic             w_timeout;
  logic             w_move;
  logic [2:0]       w_next;

  // Only the active state's request input is decoded; all others are ignored.
  always_comb begin
    w_req       = C_NONE;
    w_legal     = 1'b0;
    w_target    = S_IDLE;
    w_bad_state = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = st_idle;
        if (st_idle == C_WAIT) begin
          w_legal  = 1'b1;
          w_target = S_WAIT;
        end
      end
      S_WAIT: begin
        w_req = st_wait;
        case (st_wait)
          C_GO:    begin w_legal = 1'b1; w_target = S_GO;    end
          C_FALSE: begin w_legal = 1'b1; w_target = S_FALSE; end
          C_IDLE:  begin w_legal = 1'b1; w_target = S_IDLE;  end
          default: ;
        endcase
      end
      S_GO: begin
        w_req = st_go;
        case (st_go)
          C_RESULT: begin w_legal = 1'b1; w_target = S_RESULT; end
          C_IDLE:   begin w_legal = 1'b1; w_target = S_IDLE;   end
          default: ;
        endcase
      end
      S_RESULT: begin
        w_req = st_result;
        w_legal = (st_result == C_IDLE);
      end
      S_FALSE: begin
        w_req = st_false;
        w_legal = (st_false == C_IDLE);
      end
      default: w_bad_state = 1'b1;
    endcase
  end

  assign w_terminal = (r_state == S_RESULT) || (r_state == S_FALSE);
  assign w_armed    = (r_dwell >= DWELL_MAX) && r_zero_seen;
  assign w_accept   = w_armed && w_legal;
  assign w_illegal  = w_armed && (w_req != C_NONE) && !w_legal;
  assign w_timeout  = w_terminal && (r_tmo == TMO_LAST);
  // Unreachable encodings recover to IDLE so en can never lose its one-hot form.
  assign w_move     = w_accept || w_timeout || w_bad_state;
  assign w_next     = w_accept ? w_target : (w_move ? S_IDLE : r_state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dwell     <= '0;
      r_tmo       <= '0;
      r_zero_seen <= 1'b0;
      r_changed   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= w_move;
      if (w_illegal) r_err <= 1'b1;
      if (w_move) begin
        r_dwell     <= '0;
        r_tmo       <= '0;
        r_zero_seen <= 1'b0;
      end else begin
        if (r_dwell < DWELL_MAX) r_dwell <= r_dwell + CNT_W'(1);
        if (w_req == C_NONE) r_zero_seen <= 1'b1;
        r_tmo <= w_terminal ? r_tmo + CNT_W'(1) : '0;
      end
    end
  end

  assign state       = r_state;
  assign en          = 5'b00001 << r_state;
  assign changed     = r_changed;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_reaction_state_sequencer.sv
// Bench for reaction_state_sequencer: vector table plus hand-written corner
// sequences, expected outputs queued per driven cycle and checked after the edge.
module tb_reaction_state_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] st_idle = '0, st_wait = '0, st_go = '0, st_result = '0, st_false = '0;
  logic [4:0] en;
  logic [2:0] state;
  logic       changed;
  logic       err_illegal;

  reaction_state_sequencer #(
    .DWELL_CYCLES  (4),
    .TIMEOUT_CYCLES(20),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_idle    (st_idle),
    .st_wait    (st_wait),
    .st_go      (st_go),
    .st_result  (st_result),
    .st_false   (st_false),
    .en         (en),
    .state      (state),
    .changed    (changed),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic [3:0]  ci, cw, cg, cr, cf;
    int unsigned n;
    logic [2:0]  es;
    logic        ec, ee;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       chg;
    logic       err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t       e;
    logic [4:0] oh;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cycle=%0d actual=0 expected=1", cyc);
      return;
    end
    e  = sb.pop_front();
    oh = 5'b00001 << e.st;
    cmp("state", {5'd0, state}, {5'd0, e.st});
    cmp("en", {3'd0, en}, {3'd0, oh});
    cmp("changed", {7'd0, changed}, {7'd0, e.chg});
    cmp("err_illegal", {7'd0, err_illegal}, {7'd0, e.err});
  endtask

  task automatic step(input vec_t v, input logic exp_chg);
    exp_t e;
    @(negedge clk);
    rst_n     = v.rn;
    st_idle   = v.ci;
    st_wait   = v.cw;
    st_go     = v.cg;
    st_result = v.cr;
    st_false  = v.cf;
    e.st  = v.es;
    e.chg = exp_chg;
    e.err = v.ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  // changed is expected only after the first cycle of a record.
  task automatic run_vec(input vec_t v);
    for (int unsigned k = 0; k < v.n; k++) step(v, (k == 0) ? v.ec : 1'b0);
  endtask

  task automatic row(input logic rn, input logic [3:0] ci, cw, cg, cr, cf,
                     input int unsigned n, input logic [2:0] es,
                     input logic ec, input logic ee);
    vec_t v;
    v = '{rn, ci, cw, cg, cr, cf, n, es, ec, ee};
    run_vec(v);
  endtask

  task automatic to_go(input logic ee);
    row(1, 0, 0, 0, 0, 0, 5, 0, 0, ee);
    row(1, 1, 0, 0, 0, 0, 1, 1, 1, ee);
    row(1, 0, 0, 0, 0, 0, 5, 1, 0, ee);
    row(1, 0, 2, 0, 0, 0, 1, 2, 1, ee);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    //          rn  i  w  g  r   f  n   st chg err
    tbl.push_back('{0, 1, 0, 0, 0,  0, 3,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 8,  0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 5,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 1,  1, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 0,  0, 6,  1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 5,  1, 0, 0});
    tbl.push_back('{1, 0, 2, 0, 0,  0, 1,  2, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 5,  2, 0, 0});
    tbl.push_back('{1, 0, 0, 3, 0,  0, 1,  3, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 5,  3, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 15, 0, 1,  0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 5,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0,  0, 1,  1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 1,  1, 0, 0});
    tbl.push_back('{1, 0, 4, 0, 0,  0, 1,  1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 2,  1, 0, 0});
    tbl.push_back('{1, 0, 4, 0, 0,  0, 1,  4, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 19, 4, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0,  0, 1,  0, 1, 0});
    foreach (tbl[i]) run_vec(tbl[i]);

    // RESULT timeout: back to IDLE exactly 20 cycles after entry, one pulse.
    to_go(0);
    row(1, 0, 0, 0, 0, 0, 5, 2, 0, 0);
    row(1, 0, 0, 3, 0, 0, 1, 3, 1, 0);
    row(1, 0, 0, 0, 0, 0, 19, 3, 0, 0);
    row(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    row(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);

    // Illegal code 9: ignored unarmed, flags once armed; reset mid-GO clears.
    to_go(0);
    row(1, 1, 0, 9, 0, 0, 1, 2, 0, 0);
    row(1, 1, 0, 0, 0, 0, 4, 2, 0, 0);
    row(1, 1, 0, 9, 0, 0, 1, 2, 0, 1);
    row(1, 1, 0, 0, 0, 0, 2, 2, 0, 1);
    row(0, 0, 0, 3, 0, 0, 1, 0, 0, 0);
    row(1, 1, 0, 0, 0, 0, 2, 0, 0, 0);

    // Code 1 is legal elsewhere but illegal from GO; sticky flag survives moves.
    to_go(0);
    row(1, 1, 0, 0, 0, 0, 5, 2, 0, 0);
    row(1, 1, 0, 1, 0, 0, 1, 2, 0, 1);
    row(1, 0, 0, 3, 0, 0, 1, 3, 1, 1);
    row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Illegal code coinciding with timeout: timeout wins and flag sets.
    to_go(0);
    row(1, 0, 0, 0, 0, 0, 5, 2, 0, 0);
    row(1, 0, 0, 3, 0, 0, 1, 3, 1, 0);
    row(1, 0, 0, 0, 0, 0, 19, 3, 0, 0);
    row(1, 0, 0, 0, 9, 0, 1, 0, 1, 1);
    row(1, 0, 0, 0, 0, 0, 2, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_state_sequencer.md
# reaction_state_sequencer

- Top-level state sequencer for the reaction timer.
- Owns the one-hot enable vector that activates exactly one state module (idle chase, wait, go, result, false-start).
- Consumes each module's 4-bit `out_state` request code and performs legal transitions.
- Enforces a minimum dwell and request re-arm, so a held KEY cannot cascade through several states, and times out terminal states back to idle.

## Interface
- `DWELL_CYCLES`, default 1_000_000: minimum cycles in a state before a request is accepted (20 ms at 50 MHz).
- `TIMEOUT_CYCLES`, default 500_000_000: cycles in RESULT or FALSE before an automatic return to IDLE.
- `CNT_W`, default 32: width of the dwell and timeout counters; must hold both parameters.
- `clk`  in  1  system clock (single clock domain).
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `st_idle`  in  4  request code from the idle/chase module.
- `st_wait`  in  4  request code from the wait module.
- `st_go`  in  4  request code from the go module.
- `st_result`  in  4  request code from the result module.
- `st_false`  in  4  request code from the false-start module.
- `en`  out  5  one-hot enables: bit0 IDLE, bit1 WAIT, bit2 GO, bit3 RESULT, bit4 FALSE.
- `state`  out  3  current state: 0 IDLE, 1 WAIT, 2 GO, 3 RESULT, 4 FALSE.
- `changed`  out  1  one-cycle pulse in the first cycle of a new state.
- `err_illegal`  out  1  sticky flag: an illegal code was presented while armed.

## Operation
- **Request codes:**
  - 0 = no request.
  - 1 = WAIT, 2 = GO, 3 = RESULT, 4 = FALSE, 15 = IDLE.
  - 5–14 are always illegal.
- **Request source:** only the input belonging to the current state is examined. All other inputs are ignored, whatever their value.
- **Legal transitions:**
  - IDLE→WAIT on code 1.
  - WAIT→GO on 2, WAIT→FALSE on 4, WAIT→IDLE on 15.
  - GO→RESULT on 3, GO→IDLE on 15.
  - RESULT→IDLE on 15.
  - FALSE→IDLE on 15.
- **Armed condition:** a request is accepted only when `armed` = (dwell counter ≥ DWELL_CYCLES) AND (the active input has read 0 for at least one cycle since entering the state).
- **Not-armed behaviour:** requests seen while not armed are discarded. They are never queued.
- **Illegal code while armed:** a nonzero code that is not legal from the current state leaves the state unchanged and sets `err_illegal`. `err_illegal` clears only on reset.
- **Timeout:** in RESULT or FALSE, when the timeout counter reaches TIMEOUT_CYCLES−1, the next state is IDLE. It counts as a normal transition (`changed` pulses).
- **Counter behaviour:**
  - Dwell and timeout counters clear on every transition.
  - The dwell counter saturates at DWELL_CYCLES.
  - The timeout counter counts only in RESULT and FALSE.
- **Output encoding:** `en` is always exactly one-hot and equals 1<<`state`.

## Timing
- **Reset (rst_n=0 at an edge):**
  - `state`=0, `en`=5'b00001.
  - `changed`=0, `err_illegal`=0.
  - Counters 0, zero-seen flag cleared.
- **Reset mid-operation:** the same values appear on the next edge, regardless of state or pending request.
- **Transition latency:** a legal armed request sampled at edge N gives new `state`/`en` and `changed`=1 after edge N. `changed` returns to 0 after edge N+1.
- **Zero-seen latch:** the latch occurs at the first edge, at or after the entry edge, where the active input = 0. That edge is counted as a dwell cycle.
- **Earliest acceptance:** with an input already at 0, a request is accepted at the edge after the dwell counter reaches DWELL_CYCLES.
- **Simultaneous events:**
  - Legal request and timeout in the same cycle: the request wins. Both request IDLE from terminal states, so the only visible difference is none.
  - Illegal request and timeout together: the timeout transition occurs and `err_illegal` is set.
- **Held KEY:** an input stuck at 1 after IDLE→WAIT never re-arms WAIT, so no further transition occurs until it drops to 0.
- **Wrap-around:** counters never wrap, because of saturation and the compare at TIMEOUT_CYCLES−1.

## Test plan
(Bench parameters: DWELL_CYCLES=4, TIMEOUT_CYCLES=20.)
- **Reset:** hold rst_n=0 for 3 cycles with `st_idle`=1 → `state`=0, `en`=00001, `changed`=0, `err_illegal`=0 throughout. After release, `st_idle`=1 held continuously → no transition, because no zero was seen.
- **Full flow:** `st_idle` 0 for 5 cycles then 1 → WAIT next edge with `changed` pulse. Then `st_wait` 0 for 5 cycles then 2 → GO. Then `st_go` 3 → RESULT. Then `st_result` 15 → IDLE. `en` is one-hot at every cycle.
- **Dwell:** enter WAIT with `st_wait`=0, assert 4 on the 2nd cycle → ignored. Assert again once dwell ≥4 → FALSE, exactly 1 cycle later.
- **Timeout:** enter RESULT, keep `st_result`=0 → IDLE exactly 20 cycles after entry, `changed`=1 once.
- **Illegal/ignore:** in GO while armed, drive `st_go`=1, and separately 9 → state stays GO, `err_illegal`=1 and remains set. Meanwhile `st_idle`=1 has no effect.
- **Reset mid-flow:** in GO, pulse rst_n=0 for 1 cycle → `state`=0, `en`=00001, `err_illegal`=0 on the next edge.
